// File: rtl/mult_pkg.sv
// Shared types and constants for the signed shift-add multiplier
// (sequencer and datapath).
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ADD,
    SHIFT,
    HOLD
  } mult_state_t;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier sequencer.
// It clears synchronously, increments on enable, and saturates at WIDTH-1.
module mult_iter_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  assign tc = (cnt == LAST);

  // Saturating instead of wrapping keeps Iter meaningful in HOLD for debug.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mult_control.sv
// Sequencer for the 8-bit signed shift-add multiplier. It issues the clear,
// load, add/subtract and shift strobes for WIDTH iterations per Execute press.
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Execute,
  input  logic          ClearXA_LoadB,
  input  logic          M,
  output logic          Clr_XA,
  output logic          Ld_B,
  output logic          Ld_XA,
  output logic          Sub,
  output logic          Shift_En,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Iter
);

  mult_state_t state;
  mult_state_t next_state;
  logic        last_iter;

  mult_iter_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_iter (
    .clk (Clk),
    .rst (Reset),
    .clr (state == CLR),
    .inc (state == SHIFT),
    .cnt (Iter),
    .tc  (last_iter)
  );

  // Busy/Done are registered from next_state so that they line up with the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= next_state;
      Busy  <= (next_state == CLR) || (next_state == ADD) || (next_state == SHIFT);
      Done  <= (next_state == HOLD);
    end
  end

  always_comb begin
    next_state = state;
    Clr_XA     = 1'b0;
    Ld_B       = 1'b0;
    Ld_XA      = 1'b0;
    Sub        = 1'b0;
    Shift_En   = 1'b0;
    case (state)
      IDLE: begin
        // Execute has priority over a simultaneous clear/load request.
        if (Execute) begin
          next_state = CLR;
        end else if (ClearXA_LoadB) begin
          Clr_XA = 1'b1;
          Ld_B   = 1'b1;
        end
      end
      CLR: begin
        Clr_XA     = 1'b1;
        next_state = ADD;
      end
      ADD: begin
        // The final multiplier bit carries negative weight (two's complement).
        Ld_XA      = M;
        Sub        = last_iter & M;
        next_state = SHIFT;
      end
      SHIFT: begin
        Shift_En   = 1'b1;
        next_state = last_iter ? HOLD : ADD;
      end
      HOLD: begin
        if (!Execute) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Randomized and directed bench for mult_control. It compares the DUT against
// a cycle-count model of the multiply sequence.
module tb_mult_control;

  localparam int WIDTH = 8;
  localparam int CW    = 3;
  localparam int RUN_LEN = 2 * WIDTH + 1;

  logic          Clk = 1'b0;
  logic          Reset, Execute, ClearXA_LoadB, M;
  logic          Clr_XA, Ld_B, Ld_XA, Sub, Shift_En, Busy, Done;
  logic [CW-1:0] Iter;

  mult_control #(.WIDTH(WIDTH), .CW(CW)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Execute       (Execute),
    .ClearXA_LoadB (ClearXA_LoadB),
    .M             (M),
    .Clr_XA        (Clr_XA),
    .Ld_B          (Ld_B),
    .Ld_XA         (Ld_XA),
    .Sub           (Sub),
    .Shift_En      (Shift_En),
    .Busy          (Busy),
    .Done          (Done),
    .Iter          (Iter)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = waiting, 1 = running (t counts cycles since the run started), 2 = result held.
  int       mode = 0;
  int       t = 0;
  int       iter_m = 0;
  logic [7:0] b = 8'h00;
  logic [7:0] din = 8'h00;
  int       cyc = 0;
  int       press_cyc = 0;
  bit       watch = 0;

  logic e_clr, e_ldb, e_ldxa, e_sub, e_sh, e_busy, e_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle(input logic rst, input logic exe, input logic cxl);
    Reset = rst;
    Execute = exe;
    ClearXA_LoadB = cxl;
    M = b[0];
    #4;
    e_clr = 0; e_ldb = 0; e_ldxa = 0; e_sub = 0; e_sh = 0; e_busy = 0; e_done = 0;
    if (mode == 0) begin
      if (!exe && cxl) begin e_clr = 1; e_ldb = 1; end
    end else if (mode == 1) begin
      e_busy = 1;
      if (t == 0) e_clr = 1;
      else if (t % 2 == 1) begin
        e_ldxa = M;
        e_sub  = (iter_m == WIDTH - 1) && M;
      end else e_sh = 1;
    end else begin
      e_done = 1;
    end
    check("clr_xa", 32'(Clr_XA), 32'(e_clr));
    check("ld_b", 32'(Ld_B), 32'(e_ldb));
    check("ld_xa", 32'(Ld_XA), 32'(e_ldxa));
    check("sub", 32'(Sub), 32'(e_sub));
    check("shift_en", 32'(Shift_En), 32'(e_sh));
    check("busy", 32'(Busy), 32'(e_busy));
    check("done", 32'(Done), 32'(e_done));
    check("iter", 32'(Iter), 32'(iter_m));
    check("strobe_excl", 32'(int'(Ld_XA) + int'(Shift_En) + int'(Clr_XA) > 1), 32'(0));
    if (watch && Done) begin
      check("latency", 32'(cyc - press_cyc), 32'(RUN_LEN));
      watch = 0;
    end
    @(posedge Clk);
    if (e_sh) b = {b[7], b[7:1]};
    if (e_ldb) b = din;
    if (rst) begin
      mode = 0; t = 0; iter_m = 0;
    end else begin
      case (mode)
        0: if (exe) begin
             mode = 1; t = 0; press_cyc = cyc + 1; watch = 1;
           end
        1: begin
             if (t == 0) iter_m = 0;
             else if (t % 2 == 0 && iter_m < WIDTH - 1) iter_m++;
             t++;
             if (t == RUN_LEN) mode = 2;
           end
        default: if (!exe) mode = 0;
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic load_b(input logic [7:0] v);
    din = v;
    cycle(0, 0, 1);
    cycle(0, 0, 0);
  endtask

  initial begin
    logic exe_r;
    int   guard;
    Reset = 1; Execute = 0; ClearXA_LoadB = 0; M = 0;
    repeat (2) @(posedge Clk);
    #1;

    // Reset for two cycles, then idle
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);

    // Clear/load held three cycles
    din = 8'h07;
    repeat (3) cycle(0, 0, 1);
    cycle(0, 0, 0);

    // Execute pulse with B = 0x07
    cycle(0, 1, 0);
    repeat (20) cycle(0, 0, 0);

    // B = 0xFF, Execute held 30 cycles
    load_b(8'hFF);
    repeat (30) cycle(0, 1, 0);
    repeat (3) cycle(0, 0, 0);

    // Reset during SHIFT at Iter = 3, then a fresh run
    load_b(8'h5A);
    cycle(0, 1, 0);
    guard = 0;
    while (!(mode == 1 && t == 8) && guard < 40) begin
      cycle(0, 0, 0);
      guard++;
    end
    check("reach_shift3", 32'(guard < 40), 32'(1));
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    load_b(8'h93);
    cycle(0, 1, 0);
    repeat (20) cycle(0, 0, 0);

    // Execute and clear/load together, then clear/load pulsed in HOLD
    din = 8'h3C;
    cycle(0, 1, 1);
    repeat (18) cycle(0, 1, 0);
    repeat (3) begin
      cycle(0, 1, 1);
      cycle(0, 1, 0);
    end
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    // Randomized traffic
    exe_r = 0;
    repeat (900) begin
      if ($urandom_range(0, 9) == 0) exe_r = ~exe_r;
      din = 8'($urandom);
      cycle($urandom_range(0, 79) == 0, exe_r, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_control.md
Name: mult_control

Overview:
- Sequencing FSM for the 8-bit signed shift-add multiplier; sits directly upstream of the X/A/B register datapath and 9-bit adder.
- Consumes the synchronized push-button levels (Execute, ClearXA_LoadB) and the multiplier LSB M = B[0].
- Issues the clear, load, add/subtract and shift strobes that drive exactly WIDTH add/shift iterations per Execute press.

Parameters:
- WIDTH, 8, operand width = number of add/shift iterations
- CW, $clog2(WIDTH), iteration counter width

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- Execute  input  1  synchronized, active-high run request (level)
- ClearXA_LoadB  input  1  synchronized, active-high clear X/A and load B from Din (level)
- M  input  1  current LSB of register B
- Clr_XA  output  1  clear X and A this cycle
- Ld_B  output  1  load B from Din this cycle
- Ld_XA  output  1  load adder result into X:A this cycle
- Sub  output  1  adder subtracts (A - S) instead of adding
- Shift_En  output  1  arithmetic right shift of X:A:B this cycle
- Busy  output  1  multiplication in progress
- Done  output  1  result valid, waiting for Execute release
- Iter  output  CW  current iteration index (debug)

Behaviour:
- Single clock domain on Clk. Reset is synchronous, active-high, sampled on the rising edge.
- On Reset: state = IDLE, Iter = 0, all strobes = 0, Busy = 0, Done = 0, effective the cycle after the Reset edge. Reset overrides every other input in every state, including mid-operation.
- States: IDLE, CLR, ADD, SHIFT, HOLD.
- IDLE:
  - Execute=1 -> CLR.
  - Otherwise, while ClearXA_LoadB=1, assert Clr_XA=1 and Ld_B=1 every cycle; stay in IDLE.
  - Execute and ClearXA_LoadB both high: Execute wins; Clr_XA and Ld_B are not asserted from IDLE in that cycle.
- CLR: Clr_XA=1, Busy=1, Iter <= 0; -> ADD unconditionally.
- ADD:
  - Busy=1, Ld_XA = M (Mealy; M sampled live in this cycle).
  - Sub = 1 iff Iter == WIDTH-1 and M = 1 (sign correction on the final bit); else 0.
  - -> SHIFT.
- SHIFT:
  - Busy=1, Shift_En=1.
  - Iter == WIDTH-1 -> HOLD; else Iter <= Iter+1 -> ADD.
- HOLD:
  - Done=1, Busy=0, no strobes.
  - Stay while Execute=1; Execute=0 -> IDLE.
  - ClearXA_LoadB is ignored in HOLD.
- Latency: Execute edge to first HOLD cycle = 1 + 2*WIDTH cycles (17 for WIDTH=8).
- Strobe exclusivity: Ld_XA, Shift_En and Clr_XA are never high in the same cycle. Ld_B is high only in IDLE.
- Execute held high through a full run yields exactly one multiplication; a new run requires release then re-press.
- Iter wraps never: it saturates at WIDTH-1 and is reloaded in CLR. Iter holds its value in HOLD and IDLE.
- All state, Iter, Busy and Done are registered. Ld_XA and Sub are combinational from state, Iter and M. Clr_XA and Ld_B are combinational from state and inputs.

Decomposition:
- Shared package mult_pkg: typedef enum logic [2:0] mult_state_t {IDLE, CLR, ADD, SHIFT, HOLD}; localparam MULT_WIDTH = 8. The top level and the datapath import the same package.
- One natural sub-module, mult_iter_counter: CW-bit counter with synchronous clear, increment enable and terminal-count flag (Iter == WIDTH-1).
- FSM next-state and output decode stay in mult_control.

Test Plan:
- Reset asserted for 2 cycles from any state -> next cycle IDLE, all outputs 0, Iter=0.
- IDLE, ClearXA_LoadB=1 for 3 cycles, Execute=0 -> Clr_XA=Ld_B=1 for exactly those 3 cycles; state stays IDLE.
- Execute pulse, M driven as B=0x07 shifting (M=1,1,1,0,0,0,0,0) -> CLR, then Ld_XA=1 in ADD for Iter 0-2 only, Sub never high, Shift_En 8 times, Done at cycle 17.
- B=0xFF (M=1 every ADD) -> Ld_XA in all 8 ADD cycles, Sub=1 only at Iter=7; Execute held 30 cycles -> single run, Done stays 1 until release, then IDLE.
- Reset asserted during SHIFT at Iter=3 -> IDLE next cycle, Busy=0, Iter=0; a following Execute runs a full fresh 17-cycle sequence.
- IDLE with Execute=1 and ClearXA_LoadB=1 in the same cycle -> CLR next, Ld_B never asserted; ClearXA_LoadB pulsed in HOLD -> no strobes.
